// File: rtl/alarm_scheduler.sv
// Fixed-priority alarm sequencer: latches detector events, notifies the
// messaging unit with a valid/ready handshake, then drives the siren until acked.
module alarm_scheduler #(
  parameter int HOLD_CYCLES  = 16,
  parameter int RETRY_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_alarm,
  input  logic       d_alarm,
  input  logic [3:0] w_alarm,
  input  logic       rain_alarm,
  input  logic       ack,
  input  logic       notify_ready,
  output logic       notify_valid,
  output logic [2:0] notify_code,
  output logic       siren,
  output logic [2:0] active_code,
  output logic [6:0] pending
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RETRY_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_NOTIFY = 2'd1;
  localparam logic [1:0] S_SIREN  = 2'd2;
  localparam logic [1:0] S_COOL   = 2'd3;

  // Lowest set index wins; fire (bit 0) is the highest priority.
  function automatic logic [2:0] first_set(input logic [6:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [1:0]    r_state;
  logic [6:0]    r_pending;
  logic [2:0]    r_active_code;
  logic [2:0]    r_notify_code;
  logic          r_notify_valid;
  logic          r_siren;
  logic [HW-1:0] r_hold;
  logic [RW-1:0] r_retry;
  logic          r_cool;

  logic [6:0]    w_src;
  logic [2:0]    w_sel;
  logic          w_preempt;
  logic [6:0]    w_clr;
  logic          w_ack_ok;
  logic [1:0]    w_state_nx;
  logic [2:0]    w_active_nx;
  logic [2:0]    w_code_nx;
  logic          w_valid_nx;
  logic          w_siren_nx;
  logic [HW-1:0] w_hold_nx;
  logic [RW-1:0] w_retry_nx;
  logic          w_cool_nx;

  assign w_src     = {rain_alarm, w_alarm, d_alarm, f_alarm};
  assign w_sel     = first_set(r_pending);
  assign w_preempt = |(r_pending & ((7'd1 << r_active_code) - 7'd1));
  assign w_clr     = w_ack_ok ? (7'd1 << r_active_code) : 7'd0;

  // Next-state and next-output logic; preemption outranks ack, ack outranks reminder.
  always_comb begin
    w_state_nx  = r_state;
    w_active_nx = r_active_code;
    w_code_nx   = r_notify_code;
    w_valid_nx  = r_notify_valid;
    w_siren_nx  = r_siren;
    w_hold_nx   = r_hold;
    w_retry_nx  = r_retry;
    w_cool_nx   = r_cool;
    w_ack_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_active_nx = w_sel;
          w_code_nx   = w_sel;
          w_valid_nx  = 1'b1;
          w_state_nx  = S_NOTIFY;
        end else begin
          w_state_nx  = S_IDLE;
        end
      end
      S_NOTIFY: begin
        if (notify_ready) begin
          w_valid_nx = 1'b0;
          w_siren_nx = 1'b1;
          w_hold_nx  = HW'(HOLD_CYCLES);
          w_retry_nx = {RW{1'b0}};
          w_state_nx = S_SIREN;
        end else begin
          w_state_nx = S_NOTIFY;
        end
      end
      S_SIREN: begin
        if (w_preempt) begin
          w_active_nx = w_sel;
          w_code_nx   = w_sel;
          w_valid_nx  = 1'b1;
          w_siren_nx  = 1'b0;
          w_state_nx  = S_NOTIFY;
        end else if (r_hold != {HW{1'b0}}) begin
          w_hold_nx   = r_hold - HW'(1);
        end else if (ack) begin
          w_ack_ok    = 1'b1;
          w_siren_nx  = 1'b0;
          w_cool_nx   = 1'b0;
          w_state_nx  = S_COOL;
        end else if (r_retry == RW'(RETRY_CYCLES)) begin
          w_code_nx   = r_active_code;
          w_valid_nx  = 1'b1;
          w_siren_nx  = 1'b0;
          w_state_nx  = S_NOTIFY;
        end else begin
          w_retry_nx  = r_retry + RW'(1);
        end
      end
      S_COOL: begin
        if (r_cool) begin
          w_cool_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_cool_nx  = 1'b1;
        end
      end
      default: begin
        w_valid_nx = 1'b0;
        w_siren_nx = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, counters, pending latch and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pending      <= 7'd0;
      r_active_code  <= 3'd0;
      r_notify_code  <= 3'd0;
      r_notify_valid <= 1'b0;
      r_siren        <= 1'b0;
      r_hold         <= {HW{1'b0}};
      r_retry        <= {RW{1'b0}};
      r_cool         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_pending      <= (r_pending & ~w_clr) | w_src;
      r_active_code  <= w_active_nx;
      r_notify_code  <= w_code_nx;
      r_notify_valid <= w_valid_nx;
      r_siren        <= w_siren_nx;
      r_hold         <= w_hold_nx;
      r_retry        <= w_retry_nx;
      r_cool         <= w_cool_nx;
    end
  end

  assign notify_valid = r_notify_valid;
  assign notify_code  = r_notify_code;
  assign siren        = r_siren;
  assign active_code  = r_active_code;
  assign pending      = r_pending;

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Central alarm sequencer for the smart-home controller. It latches alarm events from the fire, burglar, window-shatter and rain detectors, then serves them one at a time in fixed priority. For each event it performs a valid/ready notification handshake with the messaging unit and then drives the shared siren until the user acknowledges. It sits between `primary_module`'s alarm outputs and the single siren/notifier resource.

## Interface

Parameters:
- `HOLD_CYCLES`, default 16: minimum siren on-time per event before `ack` is accepted; must be ≥1.
- `RETRY_CYCLES`, default 64: cycles without `ack` after the hold expires before the event is re-notified; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `f_alarm`  in  1  fire alarm level; source 0, highest priority.
- `d_alarm`  in  1  burglar (door) alarm level; source 1.
- `w_alarm`  in  4  window-shatter alarm levels; bit k is source 2+k.
- `rain_alarm`  in  1  rain alarm level; source 6, lowest priority.
- `ack`  in  1  user acknowledge, one-cycle pulse.
- `notify_ready`  in  1  messaging unit accepts the notification.
- `notify_valid`  out  1  notification offered.
- `notify_code`  out  3  source index being notified.
- `siren`  out  1  siren drive.
- `active_code`  out  3  source index currently served.
- `pending`  out  7  latched, unserved events, one bit per source.

## Operation

- Pending latch: each cycle, `pending[i]` is set if source i is high. A bit clears only on an accepted ack for that source while the input is low that same cycle; if the input is still high, the set wins.
- Selection: the highest-priority pending bit wins, meaning the lowest index.
- The FSM has four states: IDLE, NOTIFY, SIREN, COOLDOWN.
- IDLE:
  - If `pending` ≠ 0: load `active_code` with the selected index and go to NOTIFY.
  - Otherwise, stay in IDLE.
- NOTIFY:
  - `notify_valid`=1 and `notify_code`=`active_code`, both held stable until `notify_ready`=1.
  - On handshake: go to SIREN and load the hold counter with `HOLD_CYCLES`.
- SIREN:
  - `siren`=1.
  - The hold counter decrements to 0; after that, the retry counter counts up.
  - `ack` is accepted only when the hold counter is 0. On accept: clear `pending[active_code]` per the latch rule and go to COOLDOWN.
  - Preemption: if any pending bit with index < `active_code` is set, load the new index and go to NOTIFY. The preempted bit stays pending.
  - Reminder: if the retry counter reaches `RETRY_CYCLES` without `ack`, go to NOTIFY with the same code.
- COOLDOWN: `siren`=0 for 2 cycles, then go to IDLE.
- `ack` is ignored in IDLE, NOTIFY and COOLDOWN, and in SIREN while the hold counter is nonzero.
- `notify_ready` is ignored when `notify_valid`=0.
- Counter widths are `$clog2(param+1)`. Counters never wrap; they saturate at their terminal value.

## Timing

- All outputs are registered (Moore).
- Reset values: `notify_valid`=0, `notify_code`=0, `siren`=0, `active_code`=0, `pending`=0; state IDLE; counters 0.
- Latency, with a source rising before edge t:
  - `pending` bit visible after edge t.
  - `notify_valid`=1 after edge t+1.
  - With `notify_ready` already high: handshake completes on edge t+2, and `siren`=1 after edge t+2.
- Siren minimum on-time is `HOLD_CYCLES` cycles. The earliest ack is accepted on the edge at which the hold counter reads 0.
- Simultaneous events:
  - Reset beats everything.
  - Preemption beats ack; the ack is dropped.
  - Preemption beats reminder.
  - A pending set beats a pending clear.
- Reset mid-operation: `siren` and `notify_valid` drop after the reset edge, and all pending events are discarded.
- Back-to-back events: one full COOLDOWN of 2 cycles with `siren`=0 always separates two siren periods, except on preemption, where the siren drops only for the NOTIFY cycles.

## Test plan

Unless stated otherwise, benches run with `HOLD_CYCLES`=4 and `RETRY_CYCLES`=8.

- Single event: `rain_alarm` pulse of 1 cycle, `notify_ready`=1 → `notify_code`=6 for 1 cycle, `siren` high. An `ack` after 4 siren cycles clears `pending[6]`; `siren` is low for 2 COOLDOWN cycles, then IDLE.
- Early ack: `ack` in the 2nd siren cycle → ignored, `siren` stays high. A second `ack` after the hold expires is accepted.
- Preemption: `w_alarm`=4'b0001 (code 2) served, siren on; `f_alarm` pulse → NOTIFY with code 0. After code 0 is acked, code 2 is re-notified.
- Backpressure: `d_alarm` raised, `notify_ready`=0 for 10 cycles → `notify_valid`=1 and `notify_code`=1 held stable, `siren`=0. Raising `notify_ready` gives `siren`=1 on the next cycle.
- Reminder and sticky source:
  - No `ack` for 8 cycles after the hold expires → `notify_valid` reasserts with the same code.
  - `ack` while `f_alarm` is still high → `pending[0]` stays 1 and code 0 is re-served after COOLDOWN.
- Reset: assert `reset` during SIREN with pending=7'b1000101 → all outputs 0 and `pending`=0 on the next cycle.
